// File: rtl/wb_upsizer_pkg.sv
// rtl/wb_upsizer_pkg.sv - Wishbone cycle-type constants and lane/alignment helpers for wb_upsizer
package wb_upsizer_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   // Which narrow lane of the wide word a byte address falls in.
   function automatic logic [31:0] lane_index(input logic [63:0] adr,
                                              input int unsigned byte_bits,
                                              input int unsigned lane_bits);
      logic [63:0] mask;
      mask = (64'd1 << lane_bits) - 64'd1;
      return 32'((adr >> byte_bits) & mask);
   endfunction

   function automatic logic [63:0] align_addr(input logic [63:0] adr,
                                              input int unsigned off_bits);
      return adr & ~((64'd1 << off_bits) - 64'd1);
   endfunction

endpackage

// File: rtl/wb_upsizer_rdbuf.sv
// rtl/wb_upsizer_rdbuf.sv - single-line read buffer (data/tag/valid, hit detect); present only with WB_UPSIZER_READ_BUF_EN
`ifdef WB_UPSIZER_READ_BUF_EN
module wb_upsizer_rdbuf #(
   parameter int DW_OUT = 64,
   parameter int AW     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cyc,
   input  logic              stb,
   input  logic              we,
   input  logic [AW-1:0]     line_adr,
   input  logic              m_ack,
   input  logic              m_err,
   input  logic              m_rty,
   input  logic [DW_OUT-1:0] m_dat,
   output logic              hit,
   output logic [DW_OUT-1:0] buf_dat
);

   logic [AW-1:0] tag;
   logic          valid;

   assign hit = valid & (tag == line_adr) & cyc & stb & ~we;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         tag     <= '0;
         buf_dat <= '0;
      end else if (!cyc || (stb && we) || m_err || m_rty) begin
         valid <= 1'b0;
      end else if (stb && !hit && m_ack) begin
         // Only a clean downstream read completion may fill the line.
         valid   <= 1'b1;
         tag     <= line_adr;
         buf_dat <= m_dat;
      end
   end

endmodule
`endif

// File: rtl/wb_upsizer.sv
// rtl/wb_upsizer.sv - narrow-to-wide Wishbone bridge; optional read buffer under WB_UPSIZER_READ_BUF_EN
module wb_upsizer
   import wb_upsizer_pkg::*;
#(
   parameter int DW_IN = 32,
   parameter int SCALE = 2,
   parameter int AW    = 32
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic [AW-1:0]             wbs_adr_i,
   input  logic [DW_IN-1:0]          wbs_dat_i,
   input  logic [DW_IN/8-1:0]        wbs_sel_i,
   input  logic                      wbs_we_i,
   input  logic                      wbs_cyc_i,
   input  logic                      wbs_stb_i,
   input  logic [2:0]                wbs_cti_i,
   input  logic [1:0]                wbs_bte_i,
   output logic [DW_IN-1:0]          wbs_dat_o,
   output logic                      wbs_ack_o,
   output logic                      wbs_err_o,
   output logic                      wbs_rty_o,
   output logic [AW-1:0]             wbm_adr_o,
   output logic [DW_IN*SCALE-1:0]    wbm_dat_o,
   output logic [DW_IN*SCALE/8-1:0]  wbm_sel_o,
   output logic                      wbm_we_o,
   output logic                      wbm_cyc_o,
   output logic                      wbm_stb_o,
   output logic [2:0]                wbm_cti_o,
   output logic [1:0]                wbm_bte_o,
   input  logic [DW_IN*SCALE-1:0]    wbm_dat_i,
   input  logic                      wbm_ack_i,
   input  logic                      wbm_err_i,
   input  logic                      wbm_rty_i
);

   localparam int          DW_OUT    = DW_IN * SCALE;
   localparam int          SELW_IN   = DW_IN / 8;
   localparam int          SELW_OUT  = DW_OUT / 8;
   localparam int unsigned BYTE_BITS = $clog2(SELW_IN);
   localparam int unsigned LANE_BITS = $clog2(SCALE);
   localparam int unsigned OFF_BITS  = $clog2(SELW_OUT);

   logic [31:0]       lane;
   logic [AW-1:0]     line_adr;
   logic              run;
   logic              acc;
   logic              hit;
   logic [DW_OUT-1:0] buf_dat;
   logic [DW_OUT-1:0] rd_src;
   logic              unused;

   assign run      = wb_rst_i;
   assign acc      = run & wbs_cyc_i & wbs_stb_i;
   assign lane     = lane_index(64'(wbs_adr_i), BYTE_BITS, LANE_BITS);
   assign line_adr = AW'(align_addr(64'(wbs_adr_i), OFF_BITS));

   assign wbm_adr_o = line_adr;
   assign wbm_dat_o = {SCALE{wbs_dat_i}};
   assign wbm_sel_o = SELW_OUT'(SELW_OUT'(wbs_sel_i) << (lane * SELW_IN));
   assign wbm_we_o  = wbs_we_i;
   assign wbm_cti_o = CTI_CLASSIC;
   assign wbm_bte_o = BTE_LINEAR;
   assign wbm_cyc_o = run & wbs_cyc_i;
   assign wbm_stb_o = acc & ~hit;

   // err outranks rty outranks ack so a misbehaving slave can never raise two at once.
   assign wbs_err_o = acc & ~hit & wbm_err_i;
   assign wbs_rty_o = acc & ~hit & ~wbm_err_i & wbm_rty_i;
   assign wbs_ack_o = acc & (hit | (wbm_ack_i & ~wbm_err_i & ~wbm_rty_i));

   assign rd_src    = hit ? buf_dat : wbm_dat_i;
   assign wbs_dat_o = DW_IN'(rd_src >> (lane * DW_IN));

`ifdef WB_UPSIZER_READ_BUF_EN
   wb_upsizer_rdbuf #(
      .DW_OUT (DW_OUT),
      .AW     (AW)
   ) u_rdbuf (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_i),
      .cyc      (wbs_cyc_i),
      .stb      (wbs_stb_i),
      .we       (wbs_we_i),
      .line_adr (line_adr),
      .m_ack    (wbm_ack_i),
      .m_err    (wbm_err_i),
      .m_rty    (wbm_rty_i),
      .m_dat    (wbm_dat_i),
      .hit      (hit),
      .buf_dat  (buf_dat)
   );
   assign unused = &{1'b0, wbs_cti_i, wbs_bte_i};
`else
   assign hit     = 1'b0;
   assign buf_dat = '0;
   assign unused  = &{1'b0, wb_clk_i, wbs_cti_i, wbs_bte_i};
`endif

endmodule

// File: tb/tb_wb_upsizer.sv
// tb/tb_wb_upsizer.sv - randomized self-checking bench for wb_upsizer against a line-memory/buffer reference model
module tb_wb_upsizer;
   import wb_upsizer_pkg::*;

   localparam int DW_IN = 32;
   localparam int SCALE = 2;
   localparam int AW    = 32;
`ifdef WB_UPSIZER_READ_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] s_adr = '0;
   logic [31:0] s_dat = '0;
   logic [3:0]  s_sel = '0;
   logic        s_we = 1'b0, s_cyc = 1'b0, s_stb = 1'b0;
   logic [2:0]  s_cti = '0;
   logic [1:0]  s_bte = '0;
   logic [31:0] wbs_dat_o;
   logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
   logic [31:0] wbm_adr_o;
   logic [63:0] wbm_dat_o;
   logic [7:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
   logic [2:0]  wbm_cti_o;
   logic [1:0]  wbm_bte_o;
   logic [63:0] m_dat = '0;
   logic        m_ack = 1'b0, m_err = 1'b0, m_rty = 1'b0;

   int checks = 0;
   int errors = 0;
   int dn_acks = 0;
   int up_acks = 0;

   logic [63:0] mem [logic [31:0]];
   bit          ref_valid = 1'b0;
   logic [31:0] ref_tag = '0;

   always #5 clk = ~clk;

   wb_upsizer #(.DW_IN(DW_IN), .SCALE(SCALE), .AW(AW)) dut (
      .wb_clk_i (clk),       .wb_rst_i (rstn),
      .wbs_adr_i(s_adr),     .wbs_dat_i(s_dat),     .wbs_sel_i(s_sel),
      .wbs_we_i (s_we),      .wbs_cyc_i(s_cyc),     .wbs_stb_i(s_stb),
      .wbs_cti_i(s_cti),     .wbs_bte_i(s_bte),
      .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
      .wbm_dat_i(m_dat),     .wbm_ack_i(m_ack),     .wbm_err_i(m_err),     .wbm_rty_i(m_rty)
   );

   function automatic logic [63:0] rd_mem(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 64'h0;
   endfunction

   task automatic clear_resp();
      m_ack = 1'b0;
      m_err = 1'b0;
      m_rty = 1'b0;
      m_dat = {$urandom, $urandom};
   endtask

   // One upstream beat; resp: 0 ack, 1 err, 2 rty after 'waits' downstream wait states.
   task automatic beat(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti, input int waits,
                       input int resp, output logic [31:0] rdata);
      logic [31:0] al;
      int          lane;
      bit          exp_hit, done;
      logic [2:0]  exp_resp, got_resp;
      logic [63:0] line;
      logic [31:0] exp_rd;
      al      = adr - (adr % 8);
      lane    = (adr % 8) / 4;
      exp_hit = BUF && !we && ref_valid && (ref_tag == al);
      s_adr = adr; s_we = we; s_dat = dat; s_sel = sel; s_cti = cti; s_bte = 2'b01;
      s_cyc = 1'b1; s_stb = 1'b1;
      done = 1'b0; rdata = '0;
      for (int c = 0; c < 8 && !done; c++) begin
         clear_resp();
         #1;
         checks++;
         if (wbm_stb_o !== !exp_hit) begin
            errors++; $display("FAIL stb_gate adr=%h: got %b expected %b", adr, wbm_stb_o, !exp_hit);
         end
         if (c == 0 && !exp_hit) begin
            checks++;
            if (wbm_adr_o !== al) begin
               errors++; $display("FAIL wbm_adr adr=%h: got %h expected %h", adr, wbm_adr_o, al);
            end
            checks++;
            if (wbm_sel_o !== (8'(sel) << (4 * lane))) begin
               errors++; $display("FAIL wbm_sel adr=%h: got %h expected %h", adr, wbm_sel_o, 8'(sel) << (4 * lane));
            end
            checks++;
            if (wbm_dat_o !== {dat, dat}) begin
               errors++; $display("FAIL wbm_dat adr=%h: got %h expected %h", adr, wbm_dat_o, {dat, dat});
            end
            checks++;
            if ({wbm_cyc_o, wbm_we_o, wbm_cti_o, wbm_bte_o} !== {1'b1, we, 3'b000, 2'b00}) begin
               errors++; $display("FAIL wbm_ctl adr=%h: got %b expected %b", adr,
                                  {wbm_cyc_o, wbm_we_o, wbm_cti_o, wbm_bte_o}, {1'b1, we, 5'b0});
            end
         end
         if (wbm_stb_o && c >= waits) begin
            m_dat = rd_mem(al);
            case (resp)
               0:       begin m_ack = 1'b1; dn_acks++; end
               1:       m_err = 1'b1;
               default: m_rty = 1'b1;
            endcase
         end
         #1;
         if (exp_hit)         exp_resp = 3'b100;
         else if (c >= waits) exp_resp = (resp == 0) ? 3'b100 : (resp == 1) ? 3'b010 : 3'b001;
         else                 exp_resp = 3'b000;
         got_resp = {wbs_ack_o, wbs_err_o, wbs_rty_o};
         checks++;
         if (got_resp !== exp_resp) begin
            errors++; $display("FAIL resp adr=%h cyc%0d: got %b expected %b", adr, c, got_resp, exp_resp);
         end
         if (wbs_ack_o === 1'b1 && !we) begin
            exp_rd = 32'(rd_mem(al) >> (32 * lane));
            checks++;
            if (wbs_dat_o !== exp_rd) begin
               errors++; $display("FAIL rdata adr=%h: got %h expected %h", adr, wbs_dat_o, exp_rd);
            end
         end
         if (got_resp != 3'b000) begin
            done = 1'b1;
            rdata = wbs_dat_o;
            if (wbs_ack_o === 1'b1) up_acks++;
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         errors++; $display("FAIL timeout adr=%h: got no response expected one within 8 cycles", adr);
      end
      if (we) begin
         ref_valid = 1'b0;
         if (resp == 0) begin
            line = rd_mem(al);
            for (int b = 0; b < 4; b++)
               if (sel[b]) line[(lane * 4 + b) * 8 +: 8] = dat[b * 8 +: 8];
            mem[al] = line;
         end
      end else if (!exp_hit) begin
         if (resp == 0) begin ref_valid = BUF; ref_tag = al; end
         else ref_valid = 1'b0;
      end
      s_stb = 1'b0;
      clear_resp();
   endtask

   task automatic end_cycle();
      s_cyc = 1'b0; s_stb = 1'b0;
      @(posedge clk); #1;
      ref_valid = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; s_cyc = 1'b1; s_stb = 1'b1; s_adr = 32'h100;
      m_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbs_ack_o, wbs_err_o, wbs_rty_o} !== 5'b0) begin
         errors++; $display("FAIL reset_outputs: got %b expected 00000",
                            {wbm_cyc_o, wbm_stb_o, wbs_ack_o, wbs_err_o, wbs_rty_o});
      end
      m_ack = 1'b0; m_err = 1'b1;
      #1;
      checks++;
      if ({wbs_ack_o, wbs_err_o, wbs_rty_o} !== 3'b0) begin
         errors++; $display("FAIL reset_err_gate: got %b expected 000", {wbs_ack_o, wbs_err_o, wbs_rty_o});
      end
      clear_resp();
      rstn = 1'b1; ref_valid = 1'b0;
      end_cycle();
   endtask

   task automatic test_write();
      logic [31:0] rd;
      beat(32'h104, 1'b1, 32'hDEADBEEF, 4'hF, CTI_CLASSIC, 0, 0, rd);
      end_cycle();
      checks++;
      if (mem[32'h100] !== 64'hDEADBEEF_00000000) begin
         errors++; $display("FAIL write_lane: got %h expected DEADBEEF00000000", mem[32'h100]);
      end
   endtask

   task automatic test_classic_read();
      logic [31:0] rd;
      mem[32'h100] = 64'h11223344_55667788;
      beat(32'h100, 1'b0, '0, 4'hF, CTI_CLASSIC, 1, 0, rd);
      end_cycle();
      checks++;
      if (rd !== 32'h55667788) begin
         errors++; $display("FAIL classic_lo: got %h expected 55667788", rd);
      end
      beat(32'h104, 1'b0, '0, 4'hF, CTI_CLASSIC, 0, 0, rd);
      end_cycle();
      checks++;
      if (rd !== 32'h11223344) begin
         errors++; $display("FAIL classic_hi: got %h expected 11223344", rd);
      end
   endtask

   task automatic test_burst();
      logic [31:0] rd;
      int dn0, up0;
      mem[32'h200] = {$urandom, $urandom};
      mem[32'h208] = {$urandom, $urandom};
      dn0 = dn_acks; up0 = up_acks;
      for (int i = 0; i < 4; i++)
         beat(32'h200 + 32'(4 * i), 1'b0, '0, 4'hF, (i == 3) ? CTI_EOB : CTI_INCR, 0, 0, rd);
      end_cycle();
      checks++;
      if (dn_acks - dn0 !== (BUF ? 2 : 4)) begin
         errors++; $display("FAIL burst_dn_acks: got %0d expected %0d", dn_acks - dn0, BUF ? 2 : 4);
      end
      checks++;
      if (up_acks - up0 !== 4) begin
         errors++; $display("FAIL burst_up_acks: got %0d expected 4", up_acks - up0);
      end
   endtask

   task automatic test_write_invalidate();
      logic [31:0] rd, wd;
      wd = $urandom;
      beat(32'h200, 1'b0, '0, 4'hF, CTI_INCR, 0, 0, rd);
      beat(32'h204, 1'b1, wd, 4'hF, CTI_CLASSIC, 0, 0, rd);
      beat(32'h204, 1'b0, '0, 4'hF, CTI_CLASSIC, 0, 0, rd);
      end_cycle();
      checks++;
      if (rd !== wd) begin
         errors++; $display("FAIL write_then_read: got %h expected %h", rd, wd);
      end
   endtask

   task automatic test_err();
      logic [31:0] rd;
      int dn0;
      beat(32'h300, 1'b0, '0, 4'hF, CTI_INCR, 0, 1, rd);
      dn0 = dn_acks;
      beat(32'h304, 1'b0, '0, 4'hF, CTI_EOB, 0, 0, rd);
      end_cycle();
      checks++;
      if (dn_acks - dn0 !== 1) begin
         errors++; $display("FAIL err_then_miss: got %0d downstream acks expected 1", dn_acks - dn0);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [31:0] rd;
      beat(32'h200, 1'b0, '0, 4'hF, CTI_INCR, 0, 0, rd);
      s_adr = 32'h204; s_stb = 1'b1; rstn = 1'b0; m_ack = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({wbm_cyc_o, wbm_stb_o, wbs_ack_o, wbs_err_o, wbs_rty_o} !== 5'b0) begin
         errors++; $display("FAIL midburst_reset: got %b expected 00000",
                            {wbm_cyc_o, wbm_stb_o, wbs_ack_o, wbs_err_o, wbs_rty_o});
      end
      rstn = 1'b1; s_stb = 1'b0; ref_valid = 1'b0;
      clear_resp();
      beat(32'h204, 1'b0, '0, 4'hF, CTI_EOB, 0, 0, rd);
      end_cycle();
   endtask

   task automatic test_random();
      logic [31:0] rd;
      int r;
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         beat(32'h400 + 32'(4 * $urandom_range(0, 5)), ($urandom % 3) == 0, $urandom,
              4'($urandom_range(1, 15)), 3'($urandom), $urandom_range(0, 2),
              (r < 8) ? 0 : (r == 8) ? 1 : 2, rd);
         if ($urandom_range(0, 4) == 0) begin
            s_stb = 1'b0; m_ack = 1'b1;
            #1;
            checks++;
            if ({wbs_ack_o, wbs_err_o, wbs_rty_o} !== 3'b0) begin
               errors++; $display("FAIL idle_ack: got %b expected 000", {wbs_ack_o, wbs_err_o, wbs_rty_o});
            end
            clear_resp();
            end_cycle();
         end
      end
      end_cycle();
   endtask

   initial begin
      test_reset();
      test_write();
      test_classic_read();
      test_burst();
      test_write_invalidate();
      test_err();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
